debug_run_ctrl: RTL and testbench

Parametrised run/halt controller for the CPU debug environment. It generates the per-cycle advance strobe for the RISC-V core from four sources: a switch-selected mode, debounced step and resume buttons, a programmable slow-run divider and a PC breakpoint comparator. It also counts executed cycles. It sits between the board I/O and the CPU's halt input, replacing the fixed free-running tick counter.

---
 rtl/debug_run_ctrl_if.sv | 30 +++
 rtl/debug_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_debug_run_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_run_ctrl_if.sv
// Board/CPU-side signal bundle for the run/halt controller.
// Pure wiring, no latency.
// No backpressure: quasi-static switches, raw buttons and a per-cycle run strobe.
interface debug_run_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
);
   logic [1:0]        mode_i;
   logic              step_btn_i;
   logic              resume_btn_i;
   logic              bp_en_i;
   logic [ADDR_W-1:0] bp_addr_i;
   logic [ADDR_W-1:0] pc_i;
   logic              cpu_run_o;
   logic [CNT_W-1:0]  cycle_count_o;
   logic              bp_hit_o;
   logic [2:0]        state_o;

   // controller side
   modport slave (
      input  mode_i, step_btn_i, resume_btn_i, bp_en_i, bp_addr_i, pc_i,
      output cpu_run_o, cycle_count_o, bp_hit_o, state_o
   );

   // board / CPU side
   modport master (
      output mode_i, step_btn_i, resume_btn_i, bp_en_i, bp_addr_i, pc_i,
      input  cpu_run_o, cycle_count_o, bp_hit_o, state_o
   );
endinterface

// File: rtl/debug_run_ctrl.sv
// Run/halt controller: per-cycle CPU advance strobe from mode, buttons, slow divider, PC breakpoint.
// Grant is registered (1 cycle); button presses add 2 sync + DEBOUNCE_CYCLES + 1 edge cycles.
// No backpressure: cpu_run_o is an unconditional strobe, the CPU halts whenever it is low.
module debug_run_ctrl #(
   parameter int ADDR_W          = 32,
   parameter int CNT_W           = 32,
   parameter int DIV_PERIOD      = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic            CK_REF,
   input  logic            RST_N,
   debug_run_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STEP  = 3'd1,
      S_SLOW  = 3'd2,
      S_FREE  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   localparam int               DIV_W   = $clog2(DIV_PERIOD);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_PERIOD - 1);
   localparam int               DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);

   // bit 0 = step button, bit 1 = resume button
   logic [1:0]        w_btn_raw;
   logic [1:0]        r_sync1;
   logic [1:0]        r_sync2;
   logic [1:0]        r_acc;
   logic [1:0]        r_acc_d;
   logic [1:0]        r_press;
   logic [DB_W-1:0]   r_db_cnt [2];

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_grant;
   logic              w_mask_set;
   logic              w_match;
   logic              r_cpu_run;
   logic              r_mask;
   logic [DIV_W-1:0]  r_div;
   logic [CNT_W-1:0]  r_cnt;

   assign w_btn_raw = {bus.resume_btn_i, bus.step_btn_i};

   // After a resume the PC still sits on the breakpoint for a cycle or more;
   // r_mask keeps that stale PC from re-breaking until it moves away.
   assign w_match = bus.bp_en_i & (bus.pc_i == bus.bp_addr_i) & ~r_mask;

   function automatic state_t mode_state(input logic [1:0] m);
      case (m)
         2'b00:   return S_IDLE;
         2'b01:   return S_STEP;
         2'b10:   return S_SLOW;
         default: return S_FREE;
      endcase
   endfunction

   // Button path: 2-flop synchroniser, debounce counter, registered rising-edge pulse
   always_ff @(posedge CK_REF) begin
      if (!RST_N) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_acc       <= '0;
         r_acc_d     <= '0;
         r_press     <= '0;
         r_db_cnt[0] <= '0;
         r_db_cnt[1] <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_acc_d <= r_acc;
         r_press <= r_acc & ~r_acc_d;
         for (int b = 0; b < 2; b++) begin
            if (r_sync2[b] == r_acc[b]) begin
               r_db_cnt[b] <= '0;
            end else if (r_db_cnt[b] == DB_MAX) begin
               r_acc[b]    <= r_sync2[b];
               r_db_cnt[b] <= '0;
            end else begin
               r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
            end
         end
      end
   end

   // Next state and grant; presses not consumed by the current state are dropped
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_mask_set  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = mode_state(bus.mode_i);
         end
         S_STEP: begin
            w_grant     = r_press[0];
            w_state_nxt = mode_state(bus.mode_i);
         end
         S_SLOW: begin
            if (w_match) begin
               w_state_nxt = S_BREAK;
            end else begin
               w_grant     = (r_div == DIV_MAX);
               w_state_nxt = mode_state(bus.mode_i);
            end
         end
         S_FREE: begin
            if (w_match) begin
               w_state_nxt = S_BREAK;
            end else begin
               w_grant     = 1'b1;
               w_state_nxt = mode_state(bus.mode_i);
            end
         end
         S_BREAK: begin
            // Halt switch beats a coincident resume. BREAK is only reachable from
            // SLOW/FREE and mode_i is what selected them, so the mode we return to
            // is simply the state for the current mode_i (it also covers a switch
            // change made while halted).
            if (bus.mode_i == 2'b00) begin
               w_state_nxt = S_IDLE;
            end else if (r_press[1]) begin
               w_grant     = 1'b1;
               w_mask_set  = 1'b1;
               w_state_nxt = mode_state(bus.mode_i);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, run strobe, slow divider, breakpoint mask and saturating cycle counter
   always_ff @(posedge CK_REF) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         r_cpu_run <= 1'b0;
         r_div     <= '0;
         r_mask    <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cpu_run <= w_grant;
         // held at 0 outside SLOW so every entry starts a fresh period
         if (r_state != S_SLOW || r_div == DIV_MAX) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + 1'b1;
         end
         if (w_mask_set) begin
            r_mask <= 1'b1;
         end else if (bus.pc_i != bus.bp_addr_i) begin
            r_mask <= 1'b0;
         end
         if (r_cpu_run && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.cpu_run_o     = r_cpu_run;
   assign bus.cycle_count_o = r_cnt;
   assign bus.bp_hit_o      = (r_state == S_BREAK);
   assign bus.state_o       = r_state;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl (ADDR_W=16, CNT_W=4, DIV_PERIOD=8, DEBOUNCE_CYCLES=4).
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Expected values come from a vector table, per-cycle expectation queues and a PC scoreboard.
module tb_debug_run_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   debug_run_ctrl_if #(.ADDR_W(16), .CNT_W(4)) bus ();

   debug_run_ctrl #(
      .ADDR_W(16), .CNT_W(4), .DIV_PERIOD(8), .DEBOUNCE_CYCLES(4)
   ) dut (
      .CK_REF (clk),
      .RST_N  (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic        rst_n;
      logic [1:0]  mode;
      logic        bp_en;
      logic [15:0] pc;
      logic        exp_run;
      logic [2:0]  exp_st;
      logic        exp_hit;
      logic [3:0]  exp_cnt;
   } vec_t;

   typedef struct {
      logic       run;
      logic [2:0] st;
      logic       hit;
      logic [3:0] cnt;
   } exp_t;

   int          n_chk  = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   logic        run_q[$];
   logic [15:0] pc_q[$];
   logic [15:0] pc;
   vec_t        vecs[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] mode);
      rst_n             = 1'b0;
      bus.mode_i        = mode;
      bus.step_btn_i    = 1'b0;
      bus.resume_btn_i  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   // Expect cpu_run_o per cycle: pulse at cycle 'first' (1-based), then every 'period' (0 = once)
   task automatic run_expect(input string nm, input int n, input int first, input int period);
      logic e;
      for (int k = 1; k <= n; k++) begin
         if (first == 0 || k < first)  e = 1'b0;
         else if (period == 0)         e = (k == first);
         else                          e = (((k - first) % period) == 0);
         run_q.push_back(e);
         tick();
         chk(nm, bus.cpu_run_o, run_q.pop_front());
      end
   endtask

   // CPU model: PC advances by 4 on each granted cycle; each grant is matched
   // against the next expected executed PC from the scoreboard.
   task automatic run_pc(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         if (bus.cpu_run_o) begin
            if (pc_q.size() == 0) chk("pc_unexpected_grant", {16'd0, pc}, 32'hFFFF_FFFF);
            else                  chk("pc_executed", {16'd0, pc}, {16'd0, pc_q.pop_front()});
            pc         = pc + 16'd4;
            bus.pc_i   = pc;
         end
      end
   endtask

   initial begin
      exp_t e;
      //            rst   mode   bpen  pc     run   st    hit   cnt
      vecs[0]  = '{1'b0, 2'b11, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 4'd0};
      vecs[1]  = '{1'b0, 2'b11, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 4'd0};
      vecs[2]  = '{1'b0, 2'b11, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 4'd0};
      vecs[3]  = '{1'b1, 2'b00, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 4'd0};
      vecs[4]  = '{1'b1, 2'b11, 1'b0, 16'd0, 1'b0, 3'd3, 1'b0, 4'd0};
      vecs[5]  = '{1'b1, 2'b11, 1'b0, 16'd0, 1'b1, 3'd3, 1'b0, 4'd0};
      vecs[6]  = '{1'b1, 2'b01, 1'b0, 16'd0, 1'b1, 3'd1, 1'b0, 4'd1};
      vecs[7]  = '{1'b1, 2'b01, 1'b0, 16'd0, 1'b0, 3'd1, 1'b0, 4'd2};
      vecs[8]  = '{1'b1, 2'b10, 1'b0, 16'd0, 1'b0, 3'd2, 1'b0, 4'd2};
      vecs[9]  = '{1'b1, 2'b11, 1'b1, 16'd5, 1'b0, 3'd4, 1'b1, 4'd2};
      vecs[10] = '{1'b1, 2'b11, 1'b1, 16'd5, 1'b0, 3'd4, 1'b1, 4'd2};
      vecs[11] = '{1'b1, 2'b00, 1'b1, 16'd5, 1'b0, 3'd0, 1'b0, 4'd2};
      vecs[12] = '{1'b1, 2'b11, 1'b1, 16'd5, 1'b0, 3'd3, 1'b0, 4'd2};
      vecs[13] = '{1'b1, 2'b11, 1'b1, 16'd5, 1'b0, 3'd4, 1'b1, 4'd2};
      vecs[14] = '{1'b1, 2'b10, 1'b1, 16'd5, 1'b0, 3'd4, 1'b1, 4'd2};
      vecs[15] = '{1'b1, 2'b00, 1'b1, 16'd5, 1'b0, 3'd0, 1'b0, 4'd2};

      rst_n            = 1'b0;
      bus.mode_i       = 2'b11;
      bus.step_btn_i   = 1'b0;
      bus.resume_btn_i = 1'b0;
      bus.bp_en_i      = 1'b0;
      bus.bp_addr_i    = 16'd5;
      bus.pc_i         = 16'd0;
      pc               = 16'd0;
      #2;

      // Reset, mode following, breakpoint entry and halt override
      for (int i = 0; i < 16; i++) begin
         rst_n       = vecs[i].rst_n;
         bus.mode_i  = vecs[i].mode;
         bus.bp_en_i = vecs[i].bp_en;
         bus.pc_i    = vecs[i].pc;
         sb.push_back('{vecs[i].exp_run, vecs[i].exp_st, vecs[i].exp_hit, vecs[i].exp_cnt});
         tick();
         e = sb.pop_front();
         chk($sformatf("vec%0d_run", i), bus.cpu_run_o, e.run);
         chk($sformatf("vec%0d_state", i), bus.state_o, e.st);
         chk($sformatf("vec%0d_hit", i), bus.bp_hit_o, e.hit);
         chk($sformatf("vec%0d_cnt", i), bus.cycle_count_o, e.cnt);
      end

      // Idle after reset: no grants for 100 cycles
      bus.bp_en_i = 1'b0;
      do_reset(2'b11);
      chk("rst_cnt", bus.cycle_count_o, 0);
      chk("rst_state", bus.state_o, 0);
      bus.mode_i = 2'b00;
      run_expect("idle_run", 100, 0, 0);

      // Step mode debounce: short glitch rejected, stable press gives one pulse at cycle 8
      do_reset(2'b01);
      run_expect("step_settle", 2, 0, 0);
      bus.step_btn_i = 1'b1;
      run_expect("step_glitch", 3, 0, 0);
      bus.step_btn_i = 1'b0;
      run_expect("step_glitch_after", 20, 0, 0);
      bus.step_btn_i = 1'b1;
      run_expect("step_press", 20, 8, 0);
      chk("step_cnt", bus.cycle_count_o, 1);
      bus.step_btn_i = 1'b0;
      run_expect("step_release", 10, 0, 0);
      bus.mode_i = 2'b00;
      tick();
      bus.step_btn_i = 1'b1;
      run_expect("step_in_idle", 20, 0, 0);
      bus.step_btn_i = 1'b0;
      chk("step_idle_cnt", bus.cycle_count_o, 1);

      // Slow run: pulse every 8 cycles after entry
      do_reset(2'b00);
      bus.mode_i = 2'b10;
      tick();
      chk("slow_state", bus.state_o, 2);
      run_expect("slow_run", 50, 8, 8);
      chk("slow_cnt", bus.cycle_count_o, 6);

      // Divider wrap coinciding with a breakpoint match: no grant, BREAK
      do_reset(2'b00);
      bus.bp_en_i   = 1'b1;
      bus.bp_addr_i = 16'd8;
      bus.pc_i      = 16'd0;
      bus.mode_i    = 2'b10;
      tick();
      run_expect("wrap_pre", 7, 0, 0);
      bus.pc_i = 16'd8;
      tick();
      chk("wrap_bp_run", bus.cpu_run_o, 0);
      chk("wrap_bp_state", bus.state_o, 4);

      // Free run into breakpoint at PC 8
      do_reset(2'b00);
      bus.bp_en_i   = 1'b1;
      bus.bp_addr_i = 16'd8;
      pc            = 16'd0;
      bus.pc_i      = pc;
      pc_q          = {16'd0, 16'd4};
      bus.mode_i    = 2'b11;
      run_pc(10);
      chk("bp_grants_left", pc_q.size(), 0);
      chk("bp_run", bus.cpu_run_o, 0);
      chk("bp_hit", bus.bp_hit_o, 1);
      chk("bp_state", bus.state_o, 4);
      chk("bp_pc", {16'd0, bus.pc_i}, 8);

      // Resume: breakpoint instruction executes once, run continues without re-break
      for (int i = 0; i < 13; i++) pc_q.push_back(16'(8 + 4 * i));
      bus.resume_btn_i = 1'b1;
      run_pc(20);
      chk("resume_grants_left", pc_q.size(), 0);
      chk("resume_state", bus.state_o, 3);
      chk("resume_hit", bus.bp_hit_o, 0);
      bus.resume_btn_i = 1'b0;
      bus.mode_i       = 2'b00;
      repeat (3) tick();

      // Counter saturation at 15
      do_reset(2'b00);
      bus.bp_en_i = 1'b0;
      bus.mode_i  = 2'b11;
      repeat (20) tick();
      chk("sat_cnt", bus.cycle_count_o, 15);
      repeat (5) tick();
      chk("sat_hold", bus.cycle_count_o, 15);

      // Resume press coinciding with halt switch in BREAK: halt wins, no grant
      do_reset(2'b00);
      bus.bp_en_i   = 1'b1;
      bus.bp_addr_i = 16'd8;
      bus.pc_i      = 16'd8;
      bus.mode_i    = 2'b11;
      tick();
      tick();
      chk("ovr_break", bus.state_o, 4);
      bus.resume_btn_i = 1'b1;
      run_expect("ovr_pre", 7, 0, 0);
      bus.mode_i = 2'b00;
      tick();
      chk("ovr_run", bus.cpu_run_o, 0);
      chk("ovr_state", bus.state_o, 0);
      run_expect("ovr_after", 10, 0, 0);
      bus.resume_btn_i = 1'b0;
      chk("ovr_cnt", bus.cycle_count_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
